uart_tx_arbiter: RTL and testbench

Round-robin arbiter that shares one uart_tx instance among four byte requesters, for example the CPU OUT path, a debug dumper, and echo logic.
It selects a requester, presents the byte on tx_byte, and launches the transmitter with a 1->0 pulse on tx_fgo, which uart_tx detects as a negative edge.
It acknowledges the requester once the transmitter has gone busy, then waits for the frame to finish before re-arbitrating.
It sits between the requesters and uart_tx; tx_rdy is fed back from uart_tx.

---
 rtl/uart_tx_arbiter_if.sv | 20 ++
 rtl/uart_tx_arbiter.sv | 95 +++++++++
 tb/tb_uart_tx_arbiter.sv | 337 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
// Requester/transmitter-side signals of uart_tx_arbiter.
// master drives requests and tx_rdy; slave is the arbiter.
interface uart_tx_arbiter_if;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  ack;
  logic [7:0]  tx_byte;
  logic        tx_fgo;
  logic        tx_rdy;

  modport master (
    output req, req_data, tx_rdy,
    input  ack, tx_byte, tx_fgo
  );

  modport slave (
    input  req, req_data, tx_rdy,
    output ack, tx_byte, tx_fgo
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx between four byte requesters.
// Launches the transmitter with a 1->0 pulse on tx_fgo and acks once it goes busy.
module uart_tx_arbiter #(
  parameter int unsigned TIMEOUT   = 16,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  uart_tx_arbiter_if.slave     bus,
  output logic [1:0]           grant_id,
  output logic                 busy,
  output logic                 tx_err,
  output logic [CNT_WIDTH-1:0] tx_count
);

  localparam int unsigned TW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ARM, LAUNCH, WAIT} state_t;

  state_t        state;
  logic [1:0]    ptr;
  logic [TW-1:0] tmo_cnt;
  logic [1:0]    pick;
  logic          pick_vld;

  // First pending requester at or after ptr, wrapping modulo 4.
  always_comb begin
    pick     = ptr;
    pick_vld = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (!pick_vld && bus.req[ptr + 2'(i)]) begin
        pick_vld = 1'b1;
        pick     = ptr + 2'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      ptr         <= '0;
      tmo_cnt     <= '0;
      grant_id    <= '0;
      busy        <= 1'b0;
      tx_err      <= 1'b0;
      tx_count    <= '0;
      bus.ack     <= '0;
      bus.tx_byte <= '0;
      bus.tx_fgo  <= 1'b0;
    end else begin
      bus.ack <= '0;
      tx_err  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.tx_rdy && pick_vld) begin
            grant_id    <= pick;
            bus.tx_byte <= bus.req_data[{pick, 3'b000} +: 8];
            bus.tx_fgo  <= 1'b1;
            busy        <= 1'b1;
            state       <= ARM;
          end
        end
        ARM: begin
          bus.tx_fgo <= 1'b0;
          tmo_cnt    <= '0;
          state      <= LAUNCH;
        end
        LAUNCH: begin
          if (!bus.tx_rdy) begin
            bus.ack[grant_id] <= 1'b1;
            tx_count          <= tx_count + CNT_WIDTH'(1);
            state             <= WAIT;
          end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
            // Abandoned grants still advance ptr so a dead requester cannot starve others.
            tx_err <= 1'b1;
            ptr    <= grant_id + 2'd1;
            busy   <= 1'b0;
            state  <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        WAIT: begin
          if (bus.tx_rdy) begin
            ptr   <= grant_id + 2'd1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter with a behavioural uart_tx model.
module tb_uart_tx_arbiter;
  localparam int unsigned TIMEOUT = 16;
  localparam int unsigned FRAME   = 12;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  grant_id;
  logic        busy;
  logic        tx_err;
  logic [15:0] tx_count;

  uart_tx_arbiter_if bus();

  uart_tx_arbiter #(.TIMEOUT(TIMEOUT), .CNT_WIDTH(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .grant_id (grant_id),
    .busy     (busy),
    .tx_err   (tx_err),
    .tx_count (tx_count)
  );

  always #5 clk = ~clk;

  // uart_tx model: falling fgo seen in one cycle -> busy at the next edge for FRAME cycles.
  logic        stub_en   = 1'b0;
  logic        stub_val  = 1'b1;
  logic        model_rdy = 1'b1;
  logic        fgo_q     = 1'b0;
  int unsigned frame_cnt = 0;
  logic [7:0]  shreg     = '0;
  logic [7:0]  sent_q[$];

  assign bus.tx_rdy = stub_en ? stub_val : model_rdy;

  always @(posedge clk) begin
    fgo_q <= bus.tx_fgo;
    if (model_rdy) begin
      if (!stub_en && fgo_q && !bus.tx_fgo) begin
        model_rdy <= 1'b0;
        shreg     <= bus.tx_byte;
        frame_cnt <= FRAME;
      end
    end else if (frame_cnt == 1) begin
      model_rdy <= 1'b1;
      sent_q.push_back(shreg);
    end else begin
      frame_cnt <= frame_cnt - 1;
    end
  end

  typedef struct {
    bit          do_reset;
    logic [3:0]  req;
    logic [31:0] data;
    int unsigned n;
    logic [7:0]  ids;   // expected grant order, entry k at ids[2k+1:2k]
  } vec_t;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [1:0]  ptr_m;
  logic [15:0] count_m;
  int unsigned ack_q[$];
  bit          auto_drop = 1'b0;
  int unsigned sent_rd = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (bus.ack != 4'b0000) begin
      check("ack_onehot", 32'($onehot(bus.ack)), 1);
      check("ack_err_excl", 32'(tx_err), 0);
      for (int unsigned i = 0; i < 4; i++)
        if (bus.ack[i]) ack_q.push_back(i);
      if (auto_drop) bus.req = bus.req & ~bus.ack;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    check("rst_busy", 32'(busy), 0);
    check("rst_fgo", 32'(bus.tx_fgo), 0);
    check("rst_ack", 32'(bus.ack), 0);
    check("rst_err", 32'(tx_err), 0);
    check("rst_byte", 32'(bus.tx_byte), 0);
    check("rst_grant", 32'(grant_id), 0);
    check("rst_count", 32'(tx_count), 0);
    reset   = 1'b0;
    ptr_m   = 2'd0;
    count_m = '0;
    ack_q.delete();
  endtask

  task automatic wait_quiet(input string tag, input int unsigned budget);
    int unsigned b = budget;
    while (!(busy == 1'b0 && bus.tx_rdy == 1'b1) && b > 0) begin
      tick();
      b--;
    end
    if (b == 0) check({tag, "_quiet_timeout"}, 0, 1);
  endtask

  // Round-robin rule: pending indices ordered by distance (i - ptr) mod 4.
  function automatic logic [7:0] model_order(input logic [1:0] p, input logic [3:0] m,
                                             output int unsigned n);
    logic [7:0] ids = '0;
    n = 0;
    for (int unsigned d = 0; d < 4; d++) begin
      int unsigned idx = (32'(p) + d) % 4;
      if (m[idx]) begin
        ids[2*n +: 2] = 2'(idx);
        n++;
      end
    end
    return ids;
  endfunction

  task automatic run_batch(input string tag, input logic [3:0] mask, input logic [31:0] data,
                           input int unsigned n, input logic [7:0] ids);
    int unsigned budget;
    logic [1:0]  exp_id;
    wait_quiet(tag, 200);
    sent_rd = sent_q.size();
    ack_q.delete();
    auto_drop    = 1'b1;
    bus.req_data = data;
    bus.req      = mask;
    budget = n * (FRAME + 12) + 20;
    while (ack_q.size() < n && budget > 0) begin
      tick();
      budget--;
    end
    check({tag, "_acks"}, ack_q.size(), n);
    wait_quiet(tag, 100);
    for (int unsigned k = 0; k < n; k++) begin
      exp_id = ids[2*k +: 2];
      if (k < ack_q.size()) check({tag, "_ack_id"}, ack_q[k], 32'(exp_id));
      if (sent_rd + k < sent_q.size())
        check({tag, "_byte"}, 32'(sent_q[sent_rd + k]), 32'(data[8*exp_id +: 8]));
      else
        check({tag, "_byte_missing"}, 0, 1);
    end
    count_m = count_m + 16'(n);
    check({tag, "_count"}, 32'(tx_count), 32'(count_m));
    exp_id = ids[2*(n-1) +: 2];
    ptr_m  = exp_id + 2'd1;
  endtask

  vec_t        vecs[5];
  int unsigned n_r;
  logic [7:0]  ids_r;
  logic [3:0]  mask_r;
  logic [31:0] data_r;
  int unsigned b;
  int unsigned err_k;
  bit          flag;

  initial begin
    #500000;
    $display("FAIL watchdog: got hang expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b1, 4'b1111, 32'h4030_2010, 4, 8'he4};  // 0,1,2,3
    vecs[1] = '{1'b0, 4'b0101, 32'h00CC_00AA, 2, 8'h08};  // 0,2
    vecs[2] = '{1'b0, 4'b1010, 32'hDD00_BB00, 2, 8'h07};  // 3,1
    vecs[3] = '{1'b0, 4'b0110, 32'h00EE_FF00, 2, 8'h06};  // 2,1
    vecs[4] = '{1'b0, 4'b1001, 32'h5500_0066, 2, 8'h03};  // 3,0

    bus.req      = '0;
    bus.req_data = '0;
    do_reset();

    // Single request: latency and one-cycle fgo pulse.
    sent_rd      = sent_q.size();
    auto_drop    = 1'b1;
    bus.req_data = 32'h0000_0041;
    bus.req      = 4'b0001;
    tick();
    check("p1_fgo_e0", 32'(bus.tx_fgo), 1);
    check("p1_byte_e0", 32'(bus.tx_byte), 32'h41);
    check("p1_busy_e0", 32'(busy), 1);
    tick();
    check("p1_fgo_e1", 32'(bus.tx_fgo), 0);
    tick();
    check("p1_ack_e2", 32'(bus.ack), 0);
    tick();
    check("p1_ack_e3", 32'(bus.ack), 32'b0001);
    check("p1_count_e3", 32'(tx_count), 1);
    tick();
    check("p1_ack_e4", 32'(bus.ack), 0);
    b = 100;
    while (bus.tx_rdy == 1'b0 && b > 0) begin
      tick();
      b--;
    end
    check("p1_busy_before_rdy", 32'(busy), 1);
    tick();
    check("p1_busy_after_rdy", 32'(busy), 0);
    if (sent_q.size() > sent_rd) check("p1_frame", 32'(sent_q[sent_rd]), 32'h41);
    else check("p1_frame_missing", 0, 1);
    count_m = 16'd1;
    ptr_m   = 2'd1;

    for (int unsigned t = 0; t < 5; t++) begin
      if (vecs[t].do_reset) do_reset();
      run_batch($sformatf("vec%0d", t), vecs[t].req, vecs[t].data, vecs[t].n, vecs[t].ids);
    end

    // Continuous req on 0 and 2: grants alternate.
    wait_quiet("p3", 200);
    do_reset();
    auto_drop    = 1'b0;
    bus.req_data = 32'h0077_0066;
    bus.req      = 4'b0101;
    b = 200;
    while (ack_q.size() < 4 && b > 0) begin
      tick();
      b--;
    end
    bus.req = '0;
    check("p3_acks", ack_q.size(), 4);
    for (int unsigned k = 0; k < 4 && k < ack_q.size(); k++)
      check("p3_alt", ack_q[k], (k % 2 == 0) ? 0 : 2);
    wait_quiet("p3", 100);
    check("p3_count", 32'(tx_count), 4);
    count_m = 16'd4;
    ptr_m   = 2'd3;

    for (int r = 0; r < 10; r++) begin
      mask_r = 4'($urandom_range(15, 1));
      data_r = $urandom;
      ids_r  = model_order(ptr_m, mask_r, n_r);
      run_batch("rand", mask_r, data_r, n_r, ids_r);
    end

    // tx_rdy low blocks arbitration.
    wait_quiet("p6", 200);
    sent_rd = sent_q.size();
    ack_q.delete();
    auto_drop    = 1'b1;
    stub_en      = 1'b1;
    stub_val     = 1'b0;
    bus.req_data = 32'h0000_5A00;
    bus.req      = 4'b0010;
    flag = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.tx_fgo || busy) flag = 1'b1;
    end
    check("p6_no_grant", 32'(flag), 0);
    stub_en = 1'b0;
    tick();
    check("p6_grant_id", 32'(grant_id), 1);
    check("p6_fgo", 32'(bus.tx_fgo), 1);
    b = 100;
    while (ack_q.size() < 1 && b > 0) begin
      tick();
      b--;
    end
    check("p6_acks", ack_q.size(), 1);
    wait_quiet("p6", 100);
    if (sent_q.size() > sent_rd) check("p6_frame", 32'(sent_q[sent_rd]), 32'h5A);
    else check("p6_frame_missing", 0, 1);
    count_m = count_m + 16'd1;
    check("p6_count", 32'(tx_count), 32'(count_m));

    // Transmitter never starts: launch timeout.
    do_reset();
    stub_en      = 1'b1;
    stub_val     = 1'b1;
    auto_drop    = 1'b0;
    bus.req_data = 32'h0000_2211;
    bus.req      = 4'b0011;
    tick();
    check("p4_grant0", 32'(grant_id), 0);
    err_k = 0;
    for (int unsigned k = 1; k <= 40 && err_k == 0; k++) begin
      tick();
      if (tx_err) err_k = k;
    end
    check("p4_err_cycle", err_k, TIMEOUT + 1);
    check("p4_busy", 32'(busy), 0);
    check("p4_no_ack", ack_q.size(), 0);
    tick();
    check("p4_err_pulse", 32'(tx_err), 0);
    check("p4_next_grant", 32'(grant_id), 1);
    check("p4_next_fgo", 32'(bus.tx_fgo), 1);
    bus.req = '0;
    do_reset();
    stub_en = 1'b0;

    // Reset during WAIT mid-frame.
    wait_quiet("p5", 200);
    ack_q.delete();
    auto_drop    = 1'b1;
    bus.req_data = 32'h0033_0000;
    bus.req      = 4'b0100;
    b = 50;
    while (ack_q.size() < 1 && b > 0) begin
      tick();
      b--;
    end
    check("p5_ack", ack_q.size(), 1);
    tick();
    tick();
    check("p5_busy_wait", 32'(busy), 1);
    reset = 1'b1;
    tick();
    check("p5_busy", 32'(busy), 0);
    check("p5_fgo", 32'(bus.tx_fgo), 0);
    check("p5_ack_clr", 32'(bus.ack), 0);
    check("p5_count", 32'(tx_count), 0);
    check("p5_grant", 32'(grant_id), 0);
    reset   = 1'b0;
    ptr_m   = 2'd0;
    count_m = '0;
    run_batch("p5_after", 4'b1000, 32'h9900_0000, 1, 8'h03);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
